// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master ids for the two-master arbiter slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/ahb_addr_hold.sv
// Per-master address-phase hold: captures a request the shared bus could not
// take this cycle and presents it again until it wins with HREADY high.
module ahb_addr_hold #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] haddr,
  input  logic          active,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic          hready_m,
  input  logic          win,
  output logic          new_req,
  output logic          pend,
  output logic [AW-1:0] src_addr,
  output logic [2:0]    src_size,
  output logic          src_write
);
  logic [AW-1:0] cap_addr;
  logic [2:0]    cap_size;
  logic          cap_write;

  // A master only presents a new address while its own HREADY is high.
  assign new_req = hready_m & active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend      <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= '0;
      cap_write <= 1'b0;
    end else if (new_req && !win) begin
      pend      <= 1'b1;
      cap_addr  <= haddr;
      cap_size  <= hsize;
      cap_write <= hwrite;
    end else if (pend && win) begin
      pend      <= 1'b0;
    end
  end

  assign src_addr  = pend ? cap_addr  : haddr;
  assign src_size  = pend ? cap_size  : hsize;
  assign src_write = pend ? cap_write : hwrite;
endmodule

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: single NONSEQ transfers, losers are held and
// replayed, shared address frozen across wait states.
module ahb_lite_arbiter_2m
  import ahb_pkg::*;
#(
  parameter bit RR_EN = 1'b0,
  parameter int AW    = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic [2:0]    M0_HSIZE,
  input  logic          M0_HWRITE,
  input  logic [31:0]   M0_HWDATA,
  output logic [31:0]   M0_HRDATA,
  output logic          M0_HREADY,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic [2:0]    M1_HSIZE,
  input  logic          M1_HWRITE,
  input  logic [31:0]   M1_HWDATA,
  output logic [31:0]   M1_HRDATA,
  output logic          M1_HREADY,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic [31:0]   HRDATA,
  input  logic          HREADY,
  output logic          HMASTER
);
  localparam int NM = 2;

  logic [NM-1:0][AW-1:0] m_addr, s_addr;
  logic [NM-1:0][2:0]    m_size, s_size;
  logic [NM-1:0]         m_act, m_write, s_write, m_ready;
  logic [NM-1:0]         new_req, pend, req, win;

  logic run, lock_v, lock_id, dvalid, downer, rr_last;
  logic gnt_v, gnt_id;
  logic unused_htrans0;

  assign m_addr  = {M1_HADDR, M0_HADDR};
  assign m_size  = {M1_HSIZE, M0_HSIZE};
  assign m_write = {M1_HWRITE, M0_HWRITE};
  assign m_act   = {M1_HTRANS[1], M0_HTRANS[1]};
  assign unused_htrans0 = M0_HTRANS[0] ^ M1_HTRANS[0];

  // A master is stalled while held, or while its own data phase waits.
  assign m_ready[0] = ~pend[0] & (~(dvalid & (downer == M0)) | HREADY);
  assign m_ready[1] = ~pend[1] & (~(dvalid & (downer == M1)) | HREADY);
  assign M0_HREADY  = m_ready[0];
  assign M1_HREADY  = m_ready[1];

  assign win = {gnt_v & (gnt_id == M1) & HREADY, gnt_v & (gnt_id == M0) & HREADY};
  assign req = pend | new_req;

  for (genvar i = 0; i < NM; i++) begin : g_hold
    ahb_addr_hold #(.AW(AW)) u_hold (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .haddr     (m_addr[i]),
      .active    (m_act[i]),
      .hsize     (m_size[i]),
      .hwrite    (m_write[i]),
      .hready_m  (m_ready[i]),
      .win       (win[i]),
      .new_req   (new_req[i]),
      .pend      (pend[i]),
      .src_addr  (s_addr[i]),
      .src_size  (s_size[i]),
      .src_write (s_write[i])
    );
  end

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = M0;
    if (run) begin
      if (lock_v) begin
        gnt_v  = 1'b1;
        gnt_id = lock_id;
      end else if (req[0] && req[1]) begin
        gnt_v  = 1'b1;
        gnt_id = RR_EN ? ~rr_last : M0;
      end else if (req[0] || req[1]) begin
        gnt_v  = 1'b1;
        gnt_id = ~req[0];
      end
    end
  end

  assign HTRANS = gnt_v ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = gnt_v ? s_addr[gnt_id]  : '0;
  assign HSIZE  = gnt_v ? s_size[gnt_id]  : '0;
  assign HWRITE = gnt_v ? s_write[gnt_id] : 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      run     <= 1'b0;
      lock_v  <= 1'b0;
      lock_id <= M0;
      dvalid  <= 1'b0;
      downer  <= M0;
      rr_last <= M1;
    end else begin
      run <= 1'b1;
      // Freeze the grant while an issued address phase is being extended.
      if (HTRANS[1] && !HREADY) begin
        lock_v  <= 1'b1;
        lock_id <= gnt_id;
      end else if (HREADY) begin
        lock_v  <= 1'b0;
      end
      if (HREADY) begin
        dvalid <= gnt_v;
        if (gnt_v) begin
          downer  <= gnt_id;
          rr_last <= gnt_id;
        end
      end
    end
  end

  assign HWDATA    = downer ? M1_HWDATA : M0_HWDATA;
  assign HMASTER   = downer;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;
endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench: fixed-priority instance for most scenarios, round-robin
// instance for the alternation scenario; both share master-side stimulus.
module tb_ahb_lite_arbiter_2m;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HWRITE, M1_HWRITE, HREADY;

  logic [31:0] f_M0_HRDATA, f_M1_HRDATA, f_HADDR, f_HWDATA;
  logic        f_M0_HREADY, f_M1_HREADY, f_HWRITE, f_HMASTER;
  logic [1:0]  f_HTRANS;
  logic [2:0]  f_HSIZE;

  logic [31:0] r_HADDR, r_unused_rd0, r_unused_rd1, r_unused_wd;
  logic        r_M0_HREADY, r_M1_HREADY, r_unused_wr, r_unused_hm;
  logic [1:0]  r_HTRANS;
  logic [2:0]  r_unused_sz;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter_2m #(.RR_EN(1'b0), .AW(32)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(f_M0_HRDATA), .M0_HREADY(f_M0_HREADY),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(f_M1_HRDATA), .M1_HREADY(f_M1_HREADY),
    .HADDR(f_HADDR), .HTRANS(f_HTRANS), .HSIZE(f_HSIZE), .HWRITE(f_HWRITE),
    .HWDATA(f_HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HMASTER(f_HMASTER)
  );

  ahb_lite_arbiter_2m #(.RR_EN(1'b1), .AW(32)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(r_unused_rd0), .M0_HREADY(r_M0_HREADY),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(r_unused_rd1), .M1_HREADY(r_M1_HREADY),
    .HADDR(r_HADDR), .HTRANS(r_HTRANS), .HSIZE(r_unused_sz), .HWRITE(r_unused_wr),
    .HWDATA(r_unused_wd), .HRDATA(HRDATA), .HREADY(HREADY), .HMASTER(r_unused_hm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks land mid-cycle.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_all();
    M0_HTRANS = HTRANS_IDLE;
    M1_HTRANS = HTRANS_IDLE;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    idle_all();
    HREADY = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn   = 1'b0;
    M0_HADDR  = '0; M1_HADDR = '0;
    M0_HSIZE  = HSIZE_WORD; M1_HSIZE = HSIZE_WORD;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
    M0_HWDATA = '0; M1_HWDATA = '0;
    HRDATA    = '0;
    idle_all();
    HREADY = 1'b1;

    // Reset state
    #2;
    chk("rst_htrans",  f_HTRANS,    32'h0);
    chk("rst_haddr",   f_HADDR,     32'h0);
    chk("rst_hmaster", f_HMASTER,   32'h0);
    chk("rst_m0rdy",   f_M0_HREADY, 32'h1);
    chk("rst_m1rdy",   f_M1_HREADY, 32'h1);
    do_reset();

    // Lone M0 read
    cyc();
    M0_HADDR = 32'h0000_0100; M0_HTRANS = HTRANS_NONSEQ; M0_HSIZE = HSIZE_WORD; M0_HWRITE = 1'b0;
    settle();
    chk("lone_haddr",  f_HADDR,  32'h100);
    chk("lone_htrans", f_HTRANS, 32'h2);
    chk("lone_hsize",  f_HSIZE,  32'h2);
    cyc();
    idle_all(); HRDATA = 32'hCAFE_0001;
    settle();
    chk("lone_m0rdy",   f_M0_HREADY, 32'h1);
    chk("lone_m0rdata", f_M0_HRDATA, 32'hCAFE_0001);
    chk("lone_m1rdata", f_M1_HRDATA, 32'hCAFE_0001);
    chk("lone_hmaster", f_HMASTER,   32'h0);
    chk("lone_idle",    f_HTRANS,    32'h0);
    do_reset();

    // Fixed priority collision: M0 read vs M1 write
    cyc();
    M0_HADDR = 32'h0000_0100; M0_HTRANS = HTRANS_NONSEQ; M0_HWRITE = 1'b0;
    M1_HADDR = 32'h2000_0004; M1_HTRANS = HTRANS_NONSEQ; M1_HWRITE = 1'b1; M1_HSIZE = HSIZE_WORD;
    settle();
    chk("fix_c0_haddr", f_HADDR, 32'h100);
    cyc();
    idle_all(); M1_HWRITE = 1'b0; M1_HWDATA = 32'hDEAD_BEEF;
    settle();
    chk("fix_c1_haddr",  f_HADDR,     32'h2000_0004);
    chk("fix_c1_hwrite", f_HWRITE,    32'h1);
    chk("fix_c1_m1rdy",  f_M1_HREADY, 32'h0);
    cyc();
    settle();
    chk("fix_c2_hwdata",  f_HWDATA,    32'hDEAD_BEEF);
    chk("fix_c2_hmaster", f_HMASTER,   32'h1);
    chk("fix_c2_m1rdy",   f_M1_HREADY, 32'h1);
    do_reset();

    // Round-robin: both masters stream back-to-back NONSEQ
    begin
      int c0n = 0;
      int c1n = 0;
      logic [31:0] exp_a;
      for (int k = 0; k < 8; k++) begin
        cyc();
        M0_HADDR = 32'h100 + 32'(4 * c0n); M0_HTRANS = HTRANS_NONSEQ;
        M1_HADDR = 32'h2000 + 32'(4 * c1n); M1_HTRANS = HTRANS_NONSEQ;
        settle();
        exp_a = (k % 2 == 0) ? 32'h100 + 32'(4 * (k / 2)) : 32'h2000 + 32'(4 * (k / 2));
        chk($sformatf("rr_haddr_%0d", k), r_HADDR, exp_a);
        chk($sformatf("rr_htrans_%0d", k), r_HTRANS, 32'h2);
        chk($sformatf("rr_m0rdy_%0d", k), r_M0_HREADY, (k == 0 || k % 2 == 1) ? 32'h1 : 32'h0);
        chk($sformatf("rr_m1rdy_%0d", k), r_M1_HREADY, (k % 2 == 0) ? 32'h1 : 32'h0);
        if (r_M0_HREADY) c0n++;
        if (r_M1_HREADY) c1n++;
      end
    end
    do_reset();

    // Address held stable through wait states; M0 replayed afterwards
    cyc();
    M1_HADDR = 32'h4000_0000; M1_HTRANS = HTRANS_NONSEQ; M1_HWRITE = 1'b0; HREADY = 1'b0;
    settle();
    chk("hold_c0_haddr", f_HADDR, 32'h4000_0000);
    cyc();
    M1_HTRANS = HTRANS_IDLE; M1_HADDR = 32'h0;
    M0_HADDR = 32'h0000_0200; M0_HTRANS = HTRANS_NONSEQ;
    settle();
    chk("hold_c1_haddr", f_HADDR, 32'h4000_0000);
    cyc();
    idle_all(); M0_HADDR = 32'h0;
    settle();
    chk("hold_c2_haddr", f_HADDR,     32'h4000_0000);
    chk("hold_c2_m0rdy", f_M0_HREADY, 32'h0);
    cyc();
    HREADY = 1'b1;
    settle();
    chk("hold_c3_haddr", f_HADDR,     32'h4000_0000);
    chk("hold_c3_m0rdy", f_M0_HREADY, 32'h0);
    cyc();
    settle();
    chk("hold_c4_haddr",  f_HADDR,     32'h200);
    chk("hold_c4_htrans", f_HTRANS,    32'h2);
    chk("hold_c4_m1rdy",  f_M1_HREADY, 32'h1);
    chk("hold_c4_m0rdy",  f_M0_HREADY, 32'h0);
    cyc();
    settle();
    chk("hold_c5_m0rdy",   f_M0_HREADY, 32'h1);
    chk("hold_c5_hmaster", f_HMASTER,   32'h0);
    chk("hold_c5_idle",    f_HTRANS,    32'h0);
    do_reset();

    // M1 byte store at an unaligned address
    cyc();
    M1_HADDR = 32'h1000_0003; M1_HTRANS = HTRANS_NONSEQ; M1_HSIZE = HSIZE_BYTE; M1_HWRITE = 1'b1;
    settle();
    chk("byte_hsize",  f_HSIZE,  32'h0);
    chk("byte_haddr",  f_HADDR,  32'h1000_0003);
    chk("byte_hwrite", f_HWRITE, 32'h1);
    cyc();
    idle_all(); M1_HSIZE = HSIZE_WORD; M1_HWRITE = 1'b0;
    do_reset();

    // Reset pulse while M1 is held: pending transfer is dropped
    cyc();
    M0_HADDR = 32'h300;       M0_HTRANS = HTRANS_NONSEQ;
    M1_HADDR = 32'h5000_0000; M1_HTRANS = HTRANS_NONSEQ;
    settle();
    chk("rp_c0_haddr", f_HADDR, 32'h300);
    cyc();
    idle_all();
    settle();
    chk("rp_c1_m1rdy", f_M1_HREADY, 32'h0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("rp_in_rst_htrans", f_HTRANS,    32'h0);
    chk("rp_in_rst_m1rdy",  f_M1_HREADY, 32'h1);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
      chk($sformatf("rp_post_htrans_%0d", k), f_HTRANS,    32'h0);
      chk($sformatf("rp_post_haddr_%0d", k),  f_HADDR,     32'h0);
      chk($sformatf("rp_post_m1rdy_%0d", k),  f_M1_HREADY, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
